// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory-side target of the Sysbus request/response protocol.
// Accepts one line-sized read or write at a time, backed by an internal word array.
// Reads answer with BEATS response beats, READ_LATENCY cycles after acceptance.
// Optional build macro SYSBUS_WRITE_COMPLETION_EN: each write is answered by a single
// zero-data completion beat carrying the write tag (WRESP state).
`timescale 1ns/1ps
module sysbus_mem_responder #(
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned TAG_W        = 13,
   parameter int unsigned BEATS        = 8,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned READ_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reqcyc,
   input  logic [TAG_W-1:0]  reqtag,
   input  logic [DATA_W-1:0] req,
   output logic              reqack,
   output logic              respcyc,
   output logic [TAG_W-1:0]  resptag,
   output logic [DATA_W-1:0] resp,
   input  logic              respack
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned BW  = $clog2(BEATS);
   localparam int unsigned LW  = $clog2(READ_LATENCY + 1);
   localparam int unsigned OFF = $clog2(DATA_W / 8);

   localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);
   localparam logic [LW-1:0] LatLoad  = LW'(READ_LATENCY);
   localparam logic [LW-1:0] LatOne   = LW'(1);

`ifdef SYSBUS_WRITE_COMPLETION_EN
   typedef enum logic [2:0] {StIdle, StWData, StRWait, StRResp, StWResp} state_e;
`else
   typedef enum logic [1:0] {StIdle, StWData, StRWait, StRResp} state_e;
`endif

   state_e            state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [AW-1:0]     base_q, base_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic              mem_we;

   logic [DATA_W-1:0] mem [DEPTH];

   // Word index from the byte address; out-of-range addresses wrap by truncation.
   logic [AW-1:0] req_idx;
   logic [AW-1:0] req_base;
   logic [AW-1:0] mem_idx;

   assign req_idx  = req[OFF +: AW];
   assign req_base = {req_idx[AW-1:BW], {BW{1'b0}}};
   // Line base has its low bits clear, so the beat number simply fills them in.
   assign mem_idx  = {base_q[AW-1:BW], beat_q};

   // Only the line-index slice of the address beat is meaningful.
   logic unused_req;
   assign unused_req = ^{req, req_idx[BW-1:0]};

   // Next-state and Moore outputs; reqack never looks at reqcyc.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      base_d  = base_q;
      beat_d  = beat_q;
      lat_d   = lat_q;
      mem_we  = 1'b0;
      reqack  = 1'b0;
      respcyc = 1'b0;
      resptag = '0;
      resp    = '0;
      unique case (state_q)
         StIdle: begin
            reqack = 1'b1;
            if (reqcyc) begin
               tag_d  = reqtag;
               base_d = req_base;
               beat_d = '0;
               if (reqtag[TAG_W-1]) begin
                  state_d = StWData;
               end else begin
                  lat_d   = LatLoad;
                  state_d = StRWait;
               end
            end
         end
         StWData: begin
            reqack = 1'b1;
            if (reqcyc) begin
               mem_we = 1'b1;
               beat_d = beat_q + BW'(1);
               if (beat_q == LastBeat) begin
`ifdef SYSBUS_WRITE_COMPLETION_EN
                  state_d = StWResp;
`else
                  state_d = StIdle;
`endif
               end
            end
         end
         StRWait: begin
            lat_d = lat_q - LatOne;
            if (lat_q == LatOne) begin
               state_d = StRResp;
            end
         end
         StRResp: begin
            respcyc = 1'b1;
            resptag = tag_q;
            resp    = mem[mem_idx];
            if (respack) begin
               beat_d = beat_q + BW'(1);
               if (beat_q == LastBeat) begin
                  state_d = StIdle;
               end
            end
         end
`ifdef SYSBUS_WRITE_COMPLETION_EN
         StWResp: begin
            respcyc = 1'b1;
            resptag = tag_q;
            if (respack) begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Control state with synchronous reset; an in-flight transaction is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         tag_q   <= '0;
         base_q  <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         base_q  <= base_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
      end
   end

   // Array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_idx] <= req;
      end
   end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: scoreboard of expected response beats,
// one task per scenario, inputs driven and outputs sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_sysbus_mem_responder;

   localparam int DATA_W = 64;
   localparam int TAG_W  = 13;
   localparam int BEATS  = 8;
   localparam int DEPTH  = 1024;
   localparam int RL     = 4;
   localparam int TMO    = 200;

   logic              clk = 1'b0;
   logic              reset;
   logic              reqcyc;
   logic [TAG_W-1:0]  reqtag;
   logic [DATA_W-1:0] req;
   logic              reqack;
   logic              respcyc;
   logic [TAG_W-1:0]  resptag;
   logic [DATA_W-1:0] resp;
   logic              respack;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] model [DEPTH];
   logic [DATA_W-1:0] got_data[$];
   logic [TAG_W-1:0]  got_tag[$];

   sysbus_mem_responder #(
      .DATA_W      (DATA_W),
      .TAG_W       (TAG_W),
      .BEATS       (BEATS),
      .DEPTH       (DEPTH),
      .READ_LATENCY(RL)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .reqcyc (reqcyc),
      .reqtag (reqtag),
      .req    (req),
      .reqack (reqack),
      .respcyc(respcyc),
      .resptag(resptag),
      .resp   (resp),
      .respack(respack)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int line_base(input logic [DATA_W-1:0] addr);
      int idx;
      idx = int'((addr >> 3) & 64'(DEPTH - 1));
      return idx & ~(BEATS - 1);
   endfunction

   function automatic void push_expect(input logic [TAG_W-1:0] tag,
                                       input logic [DATA_W-1:0] addr);
      int b0;
      exp_t e;
      b0 = line_base(addr);
      for (int b = 0; b < BEATS; b++) begin
         e.data = model[b0 + b];
         e.tag  = tag;
         exp_q.push_back(e);
      end
   endfunction

   // Drives one request beat until reqack, returns 1ns after the transferring edge.
   task automatic send_beat(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
      int n;
      n = 0;
      reqcyc = 1'b1;
      reqtag = tag;
      req    = data;
      while (!reqack && n < TMO) begin
         step();
         n++;
      end
      if (!reqack) begin
         total_cnt++;
         $display("FAIL req_accept: reqack=%0b after %0d cycles, required 1", reqack, n);
         reqcyc = 1'b0;
      end else begin
         step();
         reqcyc = 1'b0;
      end
   endtask

   task automatic send_write(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] addr,
                             input logic [DATA_W-1:0] d [BEATS]);
      int b0;
      b0 = line_base(addr);
      send_beat(tag, addr);
      for (int b = 0; b < BEATS; b++) begin
         model[b0 + b] = d[b];
         send_beat(tag, d[b]);
      end
   endtask

   task automatic send_read(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] addr);
      push_expect(tag, addr);
      send_beat(tag, addr);
   endtask

   // Gathers n response beats with respack held high; lat = cycles until first respcyc.
   task automatic collect(input int n, output int lat);
      int w;
      w = 0;
      got_data.delete();
      got_tag.delete();
      respack = 1'b1;
      while (!respcyc && w < TMO) begin
         step();
         w++;
      end
      lat = w;
      while (got_data.size() < n && w < TMO) begin
         if (respcyc) begin
            got_data.push_back(resp);
            got_tag.push_back(resptag);
         end
         step();
         w++;
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      reqcyc  = 1'b0;
      reqtag  = '0;
      req     = '0;
      respack = 1'b1;
      step();
      total_cnt++;
      if (respcyc !== 1'b0) $display("FAIL reset_respcyc: got %b want 0", respcyc);
      else pass_cnt++;
      total_cnt++;
      if (resptag !== '0) $display("FAIL reset_resptag: got %h want 0", resptag);
      else pass_cnt++;
      total_cnt++;
      if (resp !== '0) $display("FAIL reset_resp: got %h want 0", resp);
      else pass_cnt++;
      step();
      reset = 1'b0;
      total_cnt++;
      if (reqack !== 1'b1) $display("FAIL reset_reqack: got %b want 1", reqack);
      else pass_cnt++;
   endtask

   task automatic test_read_zero();
      logic [DATA_W-1:0] z [BEATS];
      int lat;
      exp_t e;
      for (int b = 0; b < BEATS; b++) z[b] = '0;
      send_write(13'h1001, 64'h40, z);
      send_read(13'h0005, 64'h40);
      collect(BEATS, lat);
      total_cnt++;
      if (lat !== RL) $display("FAIL read_latency: got %0d want %0d", lat, RL);
      else pass_cnt++;
      total_cnt++;
      if (got_data.size() !== BEATS)
         $display("FAIL read_zero_count: got %0d want %0d", got_data.size(), BEATS);
      else pass_cnt++;
      for (int i = 0; i < BEATS; i++) begin
         e = exp_q.pop_front();
         if (i < got_data.size()) begin
            total_cnt++;
            if (got_data[i] !== e.data)
               $display("FAIL read_zero_data[%0d]: got %h want %h", i, got_data[i], e.data);
            else pass_cnt++;
            total_cnt++;
            if (got_tag[i] !== e.tag)
               $display("FAIL read_zero_tag[%0d]: got %h want %h", i, got_tag[i], e.tag);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (respcyc !== 1'b0) $display("FAIL read_zero_after: respcyc got %b want 0", respcyc);
      else pass_cnt++;
   endtask

   task automatic test_write_read();
      logic [DATA_W-1:0] d [BEATS];
      int lat;
      exp_t e;
      for (int b = 0; b < BEATS; b++) d[b] = 64'((b + 1) * 'h11);
      send_write(13'h1003, 64'h80, d);
      send_read(13'h0007, 64'h80);
      collect(BEATS, lat);
      total_cnt++;
      if (got_data.size() !== BEATS)
         $display("FAIL wr_rd_count: got %0d want %0d", got_data.size(), BEATS);
      else pass_cnt++;
      for (int i = 0; i < BEATS; i++) begin
         e = exp_q.pop_front();
         if (i < got_data.size()) begin
            total_cnt++;
            if (got_data[i] !== e.data)
               $display("FAIL wr_rd_data[%0d]: got %h want %h", i, got_data[i], e.data);
            else pass_cnt++;
            total_cnt++;
            if (got_tag[i] !== e.tag)
               $display("FAIL wr_rd_tag[%0d]: got %h want %h", i, got_tag[i], e.tag);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]        pat;
      logic              hold;
      logic [DATA_W-1:0] hold_data;
      int                k, xfers, w;
      exp_t              e;
      pat   = 4'b1001;
      hold  = 1'b0;
      hold_data = '0;
      k     = 0;
      xfers = 0;
      w     = 0;
      send_read(13'h000A, 64'h80);
      while (!respcyc && w < TMO) begin
         step();
         w++;
      end
      while (xfers < BEATS && w < TMO) begin
         if (hold) begin
            total_cnt++;
            if (respcyc !== 1'b1 || resp !== hold_data)
               $display("FAIL bp_hold: got cyc=%b data=%h want cyc=1 data=%h",
                        respcyc, resp, hold_data);
            else pass_cnt++;
         end
         respack = pat[3 - (k % 4)];
         k++;
         if (respcyc && respack && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== e.data || resptag !== e.tag)
               $display("FAIL bp_beat[%0d]: got %h/%h want %h/%h",
                        xfers, resp, resptag, e.data, e.tag);
            else pass_cnt++;
            xfers++;
            hold = 1'b0;
         end else if (respcyc) begin
            hold      = 1'b1;
            hold_data = resp;
         end
         step();
         w++;
      end
      respack = 1'b1;
      total_cnt++;
      if (xfers !== BEATS) $display("FAIL bp_xfers: got %0d want %0d", xfers, BEATS);
      else pass_cnt++;
      total_cnt++;
      if (respcyc !== 1'b0) $display("FAIL bp_extra: respcyc got %b want 0", respcyc);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      int   w, n, lat;
      exp_t e;
      w = 0;
      n = 0;
      send_read(13'h0006, 64'h80);
      while (!respcyc && w < TMO) begin
         step();
         w++;
      end
      push_expect(13'h0009, 64'h40);
      reqcyc = 1'b1;
      reqtag = 13'h0009;
      req    = 64'h40;
      while (respcyc && n < TMO && exp_q.size() > 0) begin
         total_cnt++;
         if (reqack !== 1'b0) $display("FAIL stall_reqack[%0d]: got %b want 0", n, reqack);
         else pass_cnt++;
         e = exp_q.pop_front();
         total_cnt++;
         if (resp !== e.data || resptag !== e.tag)
            $display("FAIL stall_beat[%0d]: got %h/%h want %h/%h", n, resp, resptag,
                     e.data, e.tag);
         else pass_cnt++;
         step();
         n++;
      end
      total_cnt++;
      if (n !== BEATS) $display("FAIL stall_xfers: got %0d want %0d", n, BEATS);
      else pass_cnt++;
      total_cnt++;
      if (respcyc !== 1'b0 || reqack !== 1'b1)
         $display("FAIL stall_idle: got cyc=%b ack=%b want cyc=0 ack=1", respcyc, reqack);
      else pass_cnt++;
      step();
      reqcyc = 1'b0;
      total_cnt++;
      if (reqack !== 1'b0) $display("FAIL stall_accepted: reqack got %b want 0", reqack);
      else pass_cnt++;
      collect(BEATS, lat);
      total_cnt++;
      if (lat !== RL) $display("FAIL stall_latency: got %0d want %0d", lat, RL);
      else pass_cnt++;
      for (int i = 0; i < BEATS; i++) begin
         e = exp_q.pop_front();
         if (i < got_data.size()) begin
            total_cnt++;
            if (got_data[i] !== e.data || got_tag[i] !== e.tag)
               $display("FAIL stall_second[%0d]: got %h/%h want %h/%h", i, got_data[i],
                        got_tag[i], e.data, e.tag);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid_write();
      logic [DATA_W-1:0] d [BEATS];
      int   lat;
      exp_t e;
      for (int b = 0; b < BEATS; b++) d[b] = 64'('hA0 + b);
      send_write(13'h1002, 64'h40, d);
      // 0x2040 aliases word index 0x008, the same line as 0x40.
      send_beat(13'h100D, 64'h2040);
      for (int b = 0; b < 3; b++) begin
         model[line_base(64'h2040) + b] = 64'('hB0 + b);
         send_beat(13'h100D, 64'('hB0 + b));
      end
      reset = 1'b1;
      step();
      total_cnt++;
      if (respcyc !== 1'b0) $display("FAIL rst_mid_respcyc: got %b want 0", respcyc);
      else pass_cnt++;
      reset = 1'b0;
      send_read(13'h000B, 64'h40);
      collect(BEATS, lat);
      total_cnt++;
      if (got_data.size() !== BEATS)
         $display("FAIL rst_mid_count: got %0d want %0d", got_data.size(), BEATS);
      else pass_cnt++;
      for (int i = 0; i < BEATS; i++) begin
         e = exp_q.pop_front();
         if (i < got_data.size()) begin
            total_cnt++;
            if (got_data[i] !== e.data || got_tag[i] !== e.tag)
               $display("FAIL rst_mid_data[%0d]: got %h/%h want %h/%h", i, got_data[i],
                        got_tag[i], e.data, e.tag);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_write_completion();
      logic [DATA_W-1:0] d [BEATS];
      int   lat;
      exp_t e;
      for (int b = 0; b < BEATS; b++) d[b] = 64'('hC0 + b);
      respack = 1'b0;
      send_write(13'h1ABC, 64'h100, d);
      for (int i = 0; i < 3; i++) begin
`ifdef SYSBUS_WRITE_COMPLETION_EN
         total_cnt++;
         if (respcyc !== 1'b1 || resptag !== 13'h1ABC || resp !== '0 || reqack !== 1'b0)
            $display("FAIL wresp_beat[%0d]: got cyc=%b tag=%h data=%h ack=%b want 1/1abc/0/0",
                     i, respcyc, resptag, resp, reqack);
         else pass_cnt++;
`else
         total_cnt++;
         if (respcyc !== 1'b0) $display("FAIL wresp_none[%0d]: got %b want 0", i, respcyc);
         else pass_cnt++;
`endif
         step();
      end
      respack = 1'b1;
      step();
      total_cnt++;
      if (respcyc !== 1'b0 || reqack !== 1'b1)
         $display("FAIL wresp_done: got cyc=%b ack=%b want cyc=0 ack=1", respcyc, reqack);
      else pass_cnt++;
      send_read(13'h000C, 64'h100);
      collect(BEATS, lat);
      for (int i = 0; i < BEATS; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= got_data.size())
            $display("FAIL wresp_read[%0d]: got no beat want %h", i, e.data);
         else if (got_data[i] !== e.data || got_tag[i] !== e.tag)
            $display("FAIL wresp_read[%0d]: got %h/%h want %h/%h", i, got_data[i],
                     got_tag[i], e.data, e.tag);
         else pass_cnt++;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      reset   = 1'b1;
      reqcyc  = 1'b0;
      reqtag  = '0;
      req     = '0;
      respack = 1'b1;
      test_reset();
      test_read_zero();
      test_write_read();
      test_backpressure();
      test_stall();
      test_reset_mid_write();
      test_write_completion();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Responder (memory-side) end of the Sysbus request/response protocol. The core is the initiator; this block is the target.
- Accepts line-sized read and write requests, serves them from an internal word array, and returns read data as multi-beat responses.
- Used as the memory target behind the core in simulation, and as the reference responder for bus-level verification.
- One transaction outstanding at a time.

Parameters:
- DATA_W, 64, width of req/resp data and address beats.
- TAG_W, 13, width of reqtag/resptag.
- BEATS, 8, data beats per line (line = BEATS*DATA_W/8 bytes).
- DEPTH, 1024, words in the internal array; must be a power of 2.
- READ_LATENCY, 4, cycles from read-request acceptance to the first response beat; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- reqcyc  in  1  initiator has a valid request beat.
- reqtag  in  TAG_W  bit TAG_W-1: 1 = write, 0 = read; remaining bits are the transaction id.
- req  in  DATA_W  byte address on the first beat; write data on subsequent beats.
- reqack  out  1  responder accepts the current request beat.
- respcyc  out  1  response beat valid.
- resptag  out  TAG_W  tag of the transaction being answered.
- resp  out  DATA_W  response data.
- respack  in  1  initiator accepts the current response beat.

Behaviour:
- Transfer rules:
  - A request beat transfers at a rising clk edge with reqcyc && reqack.
  - A response beat transfers at a rising clk edge with respcyc && respack.
  - The initiator holds req/reqtag stable until the beat transfers; the responder holds resp/resptag stable until the beat transfers.
- reqack is a Moore output: 1 in IDLE and WDATA only. It never depends combinationally on reqcyc.
- Address mapping:
  - line base index = ((addr >> 3) mod DEPTH) with the low log2(BEATS) bits cleared.
  - Beats are served or written in ascending index order from the line base; there is no critical-word-first.
  - Out-of-range addresses wrap modulo DEPTH.
- States:
  - IDLE: reqack=1.
    - Read beat transfers: latch tag and base, load the latency counter with READ_LATENCY, go to RWAIT.
    - Write beat transfers: latch tag and base, beat counter = 0, go to WDATA.
  - WDATA: reqack=1.
    - Each transferred beat writes req to mem[base+beat], then beat++.
    - The transfer of beat BEATS-1 returns the state to IDLE.
    - reqtag is ignored on data beats.
  - RWAIT: reqack=0. The counter decrements each cycle; when it reaches 1, go to RRESP on the next edge. This gives the first respcyc exactly READ_LATENCY cycles after the accepting edge.
  - RRESP: reqack=0, respcyc=1, resp=mem[base+beat], resptag = latched tag.
    - beat advances only on a transfer.
    - The transfer of beat BEATS-1 returns the state to IDLE, with respcyc=0 in the following cycle.
- Request stalls: any reqcyc raised in RWAIT or RRESP is not acknowledged. It stays pending until the state returns to IDLE.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after a transaction completes, so there is one bubble cycle minimum.
- Reset:
  - At the first edge with reset=1: state=IDLE, respcyc=0, resptag=0, resp=0, all counters 0. reqack reads 1 from the next cycle onward.
  - Reset mid-transaction abandons the transaction with no partial response. Beats already written during WDATA remain in the array.
  - Array contents are not cleared by reset.
- Width rules: beat counter is log2(BEATS) bits; latency counter is clog2(READ_LATENCY+1) bits.

Optional Feature:
- Macro: SYSBUS_WRITE_COMPLETION_EN.
- Defined: after the last write data beat transfers, the block enters WRESP. In WRESP it drives one beat with respcyc=1, resptag = latched write tag, and resp=0. It holds that beat until respack, then returns to IDLE. reqack=0 in WRESP.
- Undefined: writes complete silently; WDATA returns directly to IDLE and no WRESP state exists.

Test Plan:
- Reset, then read with reqtag=0x0005 at addr 0x40 on a pre-zeroed array, respack held 1 -> first respcyc exactly 4 cycles after acceptance; 8 beats of 0 with resptag=0x0005; respcyc=0 afterwards.
- Write, reqtag=0x1003, addr 0x80, data beats 0x11..0x88; then read with reqtag=0x0007 at addr 0x80 -> resp beats 0x11,0x22,…,0x88 in order with resptag=0x0007.
- During a read response, toggle respack 1,0,0,1 per cycle -> each beat is held stable while respack=0; no beat is skipped or repeated; exactly 8 transfers.
- Assert reqcyc with reqtag=0x0009 while in RRESP -> reqack stays 0 until the last beat transfers; the request is accepted on the first IDLE cycle.
- Assert reset after 3 of 8 write data beats, then read the line -> respcyc=0 at the edge after reset; the read returns the 3 written words then the old contents; addr 0x2040 with DEPTH=1024 aliases index 0x008.
- With SYSBUS_WRITE_COMPLETION_EN, write with reqtag=0x1ABC -> one beat with respcyc=1, resptag=0x1ABC, resp=0; without the macro, no respcyc is seen.
